// File: rtl/spram_fifo_prefetch.sv
// Valid/ready FIFO backed by a single-port RAM, with a 1-entry input stage,
// a 2-entry output prefetch buffer, an empty-path bypass, occupancy count and flags.
module spram_fifo_prefetch #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned AFULL_TH   = FIFO_DEPTH,
  parameter int unsigned AEMPTY_TH  = 1,
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned RCW        = ADDR_WIDTH + 1;
  localparam logic [RCW-1:0]       RamFull  = RCW'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] AfullTh  = CNT_WIDTH'(AFULL_TH);
  localparam logic [CNT_WIDTH-1:0] AemptyTh = CNT_WIDTH'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  ib_valid_q, ib_valid_d;
  logic [DATA_WIDTH-1:0] ib_data_q, ib_data_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [RCW-1:0]        ram_cnt_q, ram_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [DATA_WIDTH-1:0] ob_data_q [2];
  logic [DATA_WIDTH-1:0] ob_data_d [2];
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;

  logic                  clr, do_read, do_bypass, do_write, ib_leaving;
  logic                  in_hs, out_hs, ob_push;
  logic [1:0]            ob_credit, ob_keep;
  logic [DATA_WIDTH-1:0] ob_push_data;

  assign clr = rst | flush;

  // RAM slot arbitration looks only at registered state; in-flight reads hold ob credit.
  always_comb begin
    ob_credit  = ob_cnt_q + {1'b0, rd_inflight_q};
    do_read    = !clr && (ram_cnt_q != '0) && (ob_credit < 2'd2);
    do_bypass  = !clr && !do_read && ib_valid_q && (ram_cnt_q == '0) && !rd_inflight_q &&
                 (ob_cnt_q < 2'd2);
    do_write   = !clr && !do_read && !do_bypass && ib_valid_q && (ram_cnt_q < RamFull);
    ib_leaving = do_bypass | do_write;
    in_ready   = !clr && (!ib_valid_q || ib_leaving);
    in_hs      = in_valid && in_ready;
    out_hs     = (ob_cnt_q != 2'd0) && out_ready;
    ob_push    = rd_inflight_q | do_bypass;
    ob_push_data = rd_inflight_q ? rd_data_q : ib_data_q;
  end

  always_comb begin
    ib_valid_d    = ib_valid_q;
    ib_data_d     = ib_data_q;
    rd_ptr_d      = rd_ptr_q + ADDR_WIDTH'(do_read);
    wr_ptr_d      = wr_ptr_q + ADDR_WIDTH'(do_write);
    ram_cnt_d     = ram_cnt_q + RCW'(do_write) - RCW'(do_read);
    rd_inflight_d = do_read;
    ob_data_d     = ob_data_q;
    ob_keep       = ob_cnt_q;
    count_d       = count_q + CNT_WIDTH'(in_hs) - CNT_WIDTH'(out_hs);

    if (in_hs) begin
      ib_valid_d = 1'b1;
      ib_data_d  = in_data;
    end else if (ib_leaving) begin
      ib_valid_d = 1'b0;
    end

    // Pop shifts the head out first; a push then lands in the first free slot.
    if (out_hs) begin
      ob_data_d[0] = ob_data_q[1];
      ob_keep      = ob_cnt_q - 2'd1;
    end
    ob_cnt_d = ob_keep;
    if (ob_push) begin
      ob_data_d[ob_keep[0]] = ob_push_data;
      ob_cnt_d              = ob_keep + 2'd1;
    end

    if (clr) begin
      ib_valid_d    = 1'b0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      ram_cnt_d     = '0;
      rd_inflight_d = 1'b0;
      ob_cnt_d      = 2'd0;
      count_d       = '0;
    end

    afull_d  = !clr && (count_d >= AfullTh);
    aempty_d = clr || (count_d <= AemptyTh);
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= ib_data_q;
    if (do_read)  rd_data_q     <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    ib_data_q    <= ib_data_d;
    ob_data_q[0] <= ob_data_d[0];
    ob_data_q[1] <= ob_data_d[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ib_valid_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      ob_cnt_q      <= 2'd0;
      count_q       <= '0;
      afull_q       <= 1'b0;
      aempty_q      <= 1'b1;
    end else begin
      ib_valid_q    <= ib_valid_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      ob_cnt_q      <= ob_cnt_d;
      count_q       <= count_d;
      afull_q       <= afull_d;
      aempty_q      <= aempty_d;
    end
  end

  assign out_valid    = (ob_cnt_q != 2'd0);
  assign out_data     = ob_data_q[0];
  assign count        = count_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

endmodule
